// File: rtl/rv_alu_pkg.sv
// Shared definitions for the ALU control stage and the ALU execute unit:
// datapath width, operation codes and the execute-unit FSM states.
package rv_alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations. Shift codes are sequenced bit-serially by
// alu_exec_unit, so they (and unknown codes) produce 0 here.
module alu_comb
    import rv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_ADD:  y = a + b;
            ALU_XOR:  y = a ^ b;
            ALU_SUB:  y = a - b;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle ops go straight to a held result, shifts
// run one bit per cycle in a shift register before the result is held.
module alu_exec_unit
    import rv_alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    alu_state_t      state_reg, state_next;
    logic [XLEN-1:0] data_reg;
    logic [4:0]      cnt_reg;
    logic [3:0]      ctrl_reg;
    logic [XLEN-1:0] comb_y;
    logic [XLEN-1:0] shift_next;
    logic            accept;

    alu_comb #(.XLEN(XLEN)) u_alu_comb (
        .ctrl (alu_ctrl),
        .a    (src_a),
        .b    (src_b),
        .y    (comb_y)
    );

    assign accept = in_valid && (state_reg == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift(alu_ctrl) && (src_b[4:0] != 5'd0)) begin
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_SHIFT: if (cnt_reg == 5'd1) state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        busy      = (state_reg == ST_SHIFT);
        out_valid = (state_reg == ST_HOLD);
    end

    // One-bit step of the in-flight shift; SRA replicates the sign bit.
    always_comb begin
        shift_next = data_reg;
        case (ctrl_reg)
            ALU_SLL: shift_next = {data_reg[XLEN-2:0], 1'b0};
            ALU_SRL: shift_next = {1'b0, data_reg[XLEN-1:1]};
            default: shift_next = {data_reg[XLEN-1], data_reg[XLEN-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg <= '0;
            cnt_reg  <= 5'd0;
            ctrl_reg <= 4'd0;
        end else if (accept) begin
            ctrl_reg <= alu_ctrl;
            if (is_shift(alu_ctrl)) begin
                data_reg <= src_a;
                cnt_reg  <= src_b[4:0];
            end else begin
                data_reg <= comb_y;
                cnt_reg  <= 5'd0;
            end
        end else if (state_reg == ST_SHIFT) begin
            data_reg <= shift_next;
            cnt_reg  <= cnt_reg - 5'd1;
        end
    end

    assign result = data_reg;
    assign zero   = (data_reg == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected results.
module tb_alu_exec_unit;
    import rv_alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for the accept edge; inputs are dropped afterwards.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        alu_ctrl = c;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        alu_ctrl = 4'hF;
        src_a    = 32'hDEAD_BEEF;
        src_b    = 32'h1234_5678;
    endtask

    // Single-cycle op with out_ready high: result one cycle after accept, then IDLE.
    task automatic single_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        issue(c, a, b);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, result, exp);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        step();
        check({tag, "_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        $display("op %s a=%h b=%h result=%h", tag, a, b, exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = ALU_ADD;
        src_a     = 32'd1;
        src_b     = 32'd2;
        out_ready = 1'b1;
        step();
        // Reset has priority over acceptance on the same edge.
        in_valid = 1'b1;
        step();
        check("rst_state", {28'd0, in_ready, out_valid, busy, zero}, 32'b1001);
        check("rst_result", result, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        check("rst_idle", {30'd0, out_valid, in_ready}, 32'd1);

        single_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12);
        single_op("sub_eq", ALU_SUB, 32'd9, 32'd9, 32'd0);
        single_op("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        single_op("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
        single_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        single_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        single_op("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        single_op("or", ALU_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
        single_op("xor", ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        single_op("bad_code", 4'b0100, 32'h1234_5678, 32'h1111_1111, 32'd0);
        single_op("sll0", ALU_SLL, 32'd1, 32'd0, 32'd1);

        // SRA by 4: four busy cycles, result in the fifth.
        issue(ALU_SRA, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sra_busy%0d", i), {29'd0, busy, out_valid, in_ready}, 32'b100);
            step();
        end
        check("sra_valid", {29'd0, busy, out_valid, in_ready}, 32'b010);
        check("sra_result", result, 32'hF800_0000);
        step();
        check("sra_idle", {30'd0, out_valid, in_ready}, 32'd1);
        $display("op sra a=80000000 shamt=4 result=f8000000");

        // SRL by 3 fills zeros from the top.
        issue(ALU_SRL, 32'h8000_0001, 32'd3);
        step();
        step();
        check("srl_busy_last", {31'd0, busy}, 32'd1);
        step();
        check("srl_result", {out_valid, result[30:0]}, {1'b1, 31'h1000_0000});
        check("srl_msb", {31'd0, result[31]}, 32'd0);
        step();
        $display("op srl a=80000001 shamt=3 result=10000000");

        // Consumer stalls for three cycles; a new request must be ignored.
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd100, 32'd23);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            alu_ctrl = ALU_SUB;
            src_a    = 32'd1;
            src_b    = 32'd1;
            check($sformatf("stall%0d_flags", i), {30'd0, out_valid, in_ready}, 32'b10);
            check($sformatf("stall%0d_result", i), result, 32'd123);
            step();
        end
        in_valid  = 1'b0;
        check("stall_hold", {out_valid, result[30:0]}, {1'b1, 31'd123});
        out_ready = 1'b1;
        step();
        check("stall_handoff_idle", {30'd0, out_valid, in_ready}, 32'd1);
        $display("op add stalled a=100 b=23 result=123");

        // Reset during the second SHIFT cycle discards the operation.
        issue(ALU_SLL, 32'd1, 32'd10);
        step();
        check("abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_state", {28'd0, in_ready, out_valid, busy, zero}, 32'b1001);
        check("abort_result", result, 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("abort_quiet%0d", i), {31'd0, out_valid}, 32'd0);
        end
        $display("op sll aborted by reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands and alu_ctrl valid this cycle.
REQ-005 in_ready  output  1  unit can accept an operation this cycle.
REQ-006 alu_ctrl  input  4  operation code from the ALU control stage.
REQ-007 src_a  input  XLEN  operand A.
REQ-008 src_b  input  XLEN  operand B; for shifts, src_b[4:0] is the shift amount.
REQ-009 out_valid  output  1  result and zero are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 result  output  XLEN  operation result.
REQ-012 zero  output  1  high when result == 0.
REQ-013 busy  output  1  high in SHIFT state.

Function
REQ-014 Codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA; any other code SHALL yield result 0.
REQ-015 ADD/SUB SHALL wrap modulo 2^XLEN with no carry or overflow output.
REQ-016 SLT/SLTU SHALL produce 1 or 0 zero-extended to XLEN.
REQ-017 The FSM SHALL have states IDLE, SHIFT, HOLD.
REQ-018 in_ready SHALL be 1 in IDLE and 0 in SHIFT and HOLD; an operation is accepted on an edge where in_valid && in_ready.
REQ-019 On acceptance of a non-shift code, the result SHALL be computed combinationally from the inputs, registered, and the FSM SHALL go to HOLD (out_valid visible 1 cycle after acceptance).
REQ-020 On acceptance of a shift with shamt = 0, the result SHALL equal src_a and the FSM SHALL go straight to HOLD.
REQ-021 On acceptance of a shift with shamt = k > 0, the unit SHALL latch src_a into a shift register, load a counter with k, and go to SHIFT.
REQ-022 In SHIFT, each edge SHALL shift by exactly one bit: SLL fills 0 at the LSB, SRL fills 0 at the MSB, SRA replicates the MSB; the counter decrements, and the FSM goes to HOLD on the edge where the counter goes from 1 to 0 (out_valid visible k+1 cycles after acceptance).
REQ-023 In HOLD, out_valid SHALL be 1 and result/zero SHALL stay stable until out_ready is sampled high, then go to IDLE with out_valid 0 in the next cycle.
REQ-024 Back-to-back operations SHALL have at least one IDLE cycle between the result handoff and the next acceptance; no same-edge handoff-and-accept.
REQ-025 in_valid, alu_ctrl, src_a and src_b SHALL be ignored outside IDLE; operands SHALL not need to be held after acceptance.
REQ-026 out_valid SHALL be 0 in IDLE and SHIFT; result SHALL not be sampled by consumers when out_valid is 0.

Reset
REQ-027 While rst is high at an edge, the FSM SHALL enter IDLE and result SHALL be 0, with zero 1, out_valid 0, busy 0, counter 0; in_ready SHALL be 1 after the edge.
REQ-028 Reset during SHIFT or HOLD SHALL discard the in-flight operation with no output pulse.
REQ-029 rst SHALL take priority over acceptance and handoff on the same edge.

Structure
REQ-030 A shared package rv_alu_pkg SHALL hold XLEN default, the ten alu_ctrl code constants, and the FSM state typedef; the ALU control stage SHALL use the same constants.
REQ-031 Single-cycle ops SHALL live in one combinational sub-module alu_comb (ctrl, a, b -> y); the shifter FSM, counter and output register stay in alu_exec_unit.

Verification
REQ-032 Reset, then ADD a=5 b=7 with out_ready=1 -> out_valid exactly 1 cycle after accept, result=12, zero=0, then IDLE.
REQ-033 SUB a=9 b=9 -> result=0, zero=1; SUB a=0 b=1 -> result=0xFFFFFFFF.
REQ-034 SLT a=0xFFFFFFFF b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-035 SRA a=0x80000000 shamt=4 -> busy for 4 cycles, out_valid 5 cycles after accept, result=0xF8000000; SLL a=1 shamt=0 -> result=1 after 1 cycle.
REQ-036 ADD result with out_ready=0 for 3 cycles -> out_valid and result held stable, in_ready=0, and a new in_valid is ignored; handoff on cycle 4, then IDLE.
REQ-037 Assert rst on the 2nd SHIFT cycle of SLL shamt=10 -> next cycle IDLE, out_valid=0, result=0, and no result is produced for that operation.
